decode_ctrl_pipe: RTL and testbench

//  Next-generation decode control for the RV64 pipeline. Decodes one instruction per cycle into control,

---
 rtl/decode_ctrl_pipe.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: RV64 decode with in-ID branch resolution, load-use and divide
// issue stalls, feeding a valid/ready ID/EX pipeline register.
module decode_ctrl_pipe #(
    parameter int INST_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 64,
    parameter int PC_TYPE_NUM  = 4,
    parameter int IMM_TYPE_NUM = 8,
    parameter int DIV_CYCLES   = 4,
    localparam int PC_SEL_W    = $clog2(PC_TYPE_NUM),
    localparam int IMM_SEL_W   = $clog2(IMM_TYPE_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  if_valid,
    output logic                  id_ready,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  is_equal,
    input  logic                  is_lt,
    input  logic                  is_ltu,
    output logic [PC_SEL_W-1:0]   pc_sel,
    output logic                  redirect,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [ADDR_WIDTH-1:0] ex_pc,
    output logic [4:0]            ex_rd,
    output logic [4:0]            ex_rs1,
    output logic [4:0]            ex_rs2,
    output logic [IMM_SEL_W-1:0]  ex_imm_sel,
    output logic                  ex_has_imm,
    output logic                  ex_w_en,
    output logic                  ex_is_load,
    output logic                  ex_is_store,
    output logic                  ex_is_mdiv
);

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;

    localparam logic [IMM_SEL_W-1:0] IMM_I     = IMM_SEL_W'(0);
    localparam logic [IMM_SEL_W-1:0] IMM_SHAMT = IMM_SEL_W'(1);
    localparam logic [IMM_SEL_W-1:0] IMM_S     = IMM_SEL_W'(2);
    localparam logic [IMM_SEL_W-1:0] IMM_U     = IMM_SEL_W'(3);
    localparam logic [IMM_SEL_W-1:0] IMM_B     = IMM_SEL_W'(4);
    localparam logic [IMM_SEL_W-1:0] IMM_J     = IMM_SEL_W'(5);

    localparam logic [PC_SEL_W-1:0] PC_SEQ    = PC_SEL_W'(0);
    localparam logic [PC_SEL_W-1:0] PC_BRANCH = PC_SEL_W'(1);
    localparam logic [PC_SEL_W-1:0] PC_JALR   = PC_SEL_W'(2);
    localparam logic [PC_SEL_W-1:0] PC_JAL    = PC_SEL_W'(3);

    localparam int CNT_W = (DIV_CYCLES > 0) ? $clog2(DIV_CYCLES + 1) : 1;

    typedef enum logic {ST_RUN, ST_MDIV} state_t;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    logic                 dec_w_en;
    logic                 dec_load;
    logic                 dec_store;
    logic                 dec_mdiv;
    logic                 dec_has_imm;
    logic [IMM_SEL_W-1:0] dec_imm_sel;
    logic                 uses_rs1;
    logic                 uses_rs2;
    logic                 is_branch;
    logic                 is_jal;
    logic                 is_jalr;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a value held and infer a latch.
    always_comb begin
        dec_w_en    = 1'b0;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_mdiv    = 1'b0;
        dec_has_imm = 1'b0;
        dec_imm_sel = IMM_I;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_w_en    = 1'b1;
                dec_has_imm = 1'b1;
                dec_imm_sel = IMM_U;
            end
            OP_JAL: begin
                dec_w_en    = 1'b1;
                dec_has_imm = 1'b1;
                dec_imm_sel = IMM_J;
                is_jal      = 1'b1;
            end
            OP_JALR: begin
                dec_w_en    = 1'b1;
                dec_has_imm = 1'b1;
                uses_rs1    = 1'b1;
                is_jalr     = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm_sel = IMM_B;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                is_branch   = 1'b1;
            end
            OP_LOAD, OP_LOAD_FP: begin
                dec_w_en    = (opcode == OP_LOAD);
                dec_load    = 1'b1;
                dec_has_imm = 1'b1;
                uses_rs1    = 1'b1;
            end
            OP_STORE, OP_STORE_FP: begin
                dec_store   = 1'b1;
                dec_has_imm = 1'b1;
                dec_imm_sel = IMM_S;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_IMM, OP_IMM_32: begin
                dec_w_en    = 1'b1;
                dec_has_imm = 1'b1;
                dec_imm_sel = (funct3[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
                uses_rs1    = 1'b1;
            end
            OP_OP, OP_OP_32: begin
                dec_w_en    = 1'b1;
                dec_mdiv    = (funct7 == 7'b0000001) && funct3[2];
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            default: ;
        endcase
    end

    logic br_taken;

    always_comb begin
        case (funct3)
            3'b000:  br_taken = is_equal;
            3'b001:  br_taken = ~is_equal;
            3'b100:  br_taken = is_lt;
            3'b101:  br_taken = ~is_lt;
            3'b110:  br_taken = is_ltu;
            3'b111:  br_taken = ~is_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    logic   advance;
    logic   accept;
    logic   hazard;
    state_t state;
    state_t state_next;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_cnt_next;

    assign advance = ex_ready | ~ex_valid;
    assign accept  = if_valid & id_ready;
    // rd==0 loads never produce a dependency, even though the index matches x0 readers.
    assign hazard  = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                     ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            div_cnt <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        div_cnt_next = div_cnt;
        if (flush) begin
            state_next   = ST_RUN;
            div_cnt_next = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && dec_mdiv && (DIV_CYCLES > 0)) begin
                        state_next   = ST_MDIV;
                        div_cnt_next = CNT_W'(DIV_CYCLES);
                    end
                end
                ST_MDIV: begin
                    if (advance) begin
                        if (div_cnt == CNT_W'(1)) begin
                            state_next   = ST_RUN;
                            div_cnt_next = '0;
                        end else begin
                            div_cnt_next = div_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next   = ST_RUN;
                    div_cnt_next = '0;
                end
            endcase
        end
    end

    // rst_n gates id_ready so nothing is accepted while reset is asserted.
    always_comb begin
        id_ready = rst_n & advance & (state == ST_RUN) & ~hazard & ~flush;
    end

    always_comb begin
        pc_sel   = PC_SEQ;
        redirect = 1'b0;
        if (accept) begin
            if (is_branch && br_taken) begin
                pc_sel   = PC_BRANCH;
                redirect = 1'b1;
            end else if (is_jalr) begin
                pc_sel   = PC_JALR;
                redirect = 1'b1;
            end else if (is_jal) begin
                pc_sel   = PC_JAL;
                redirect = 1'b1;
            end
        end
    end

    // Data fields only load on accept; bubbles clear just the side-effecting controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_imm_sel  <= '0;
            ex_has_imm  <= 1'b0;
            ex_w_en     <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
            ex_is_mdiv  <= 1'b0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_w_en     <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
            ex_is_mdiv  <= 1'b0;
        end else if (advance) begin
            ex_valid    <= accept;
            ex_w_en     <= accept & dec_w_en & (rd != 5'd0);
            ex_is_load  <= accept & dec_load;
            ex_is_store <= accept & dec_store;
            ex_is_mdiv  <= accept & dec_mdiv;
            if (accept) begin
                ex_pc      <= pc;
                ex_rd      <= rd;
                ex_rs1     <= rs1;
                ex_rs2     <= rs2;
                ex_imm_sel <= dec_imm_sel;
                ex_has_imm <= dec_has_imm;
            end
        end
    end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: directed table of single-issue decodes plus hand-written
// sequences for load-use, divide, backpressure, flush and reset corner cases.
module tb_decode_ctrl_pipe;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_32  = 7'b0111011;
    localparam logic [63:0] PC_BASE  = 64'hFFFF_0000_8000_0000;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        is_equal;
    logic        is_lt;
    logic        is_ltu;
    logic [1:0]  pc_sel;
    logic        redirect;
    logic        ex_ready;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [2:0]  ex_imm_sel;
    logic        ex_has_imm;
    logic        ex_w_en;
    logic        ex_is_load;
    logic        ex_is_store;
    logic        ex_is_mdiv;

    decode_ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .if_valid(if_valid), .id_ready(id_ready),
        .inst(inst), .pc(pc), .is_equal(is_equal), .is_lt(is_lt), .is_ltu(is_ltu),
        .pc_sel(pc_sel), .redirect(redirect), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_imm_sel(ex_imm_sel), .ex_has_imm(ex_has_imm), .ex_w_en(ex_w_en),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_is_mdiv(ex_is_mdiv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, r2, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[11:5], r2, r1, f3, imm[4:0], op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] r1,
                                          input logic [4:0] r2);
        return {7'd0, r2, r1, f3, 5'd0, OP_BRANCH};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic [1:0]  pc_sel;
        logic        redirect;
        logic [4:0]  rd;
        logic        chk_imm;
        logic [2:0]  imm_sel;
        logic        has_imm;
        logic        w_en;
        logic        load;
        logic        store;
        logic        mdiv;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // inst, eq, lt, ltu, pc_sel, redirect, rd, chk_imm, imm_sel, has_imm, w_en, load, store, mdiv
        vecs[0]  = '{enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{enc_i(12'd3, 5'd1, 3'b001, 5'd2, OP_IMM), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd2, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{enc_s(12'd4, 5'd1, 5'd2, 3'b010, OP_STORE), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd4, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{{20'h12345, 5'd3, OP_LUI}, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd3, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{enc_b(3'b100, 5'd1, 5'd2), 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 5'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{enc_b(3'b111, 5'd1, 5'd2), 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{enc_b(3'b000, 5'd3, 5'd4), 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 5'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{enc_b(3'b001, 5'd3, 5'd4), 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 5'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{enc_b(3'b101, 5'd6, 5'd7), 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 5'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{enc_b(3'b110, 5'd6, 5'd7), 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{enc_i(12'd0, 5'd5, 3'b000, 5'd1, OP_JALR), 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 5'd1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{{20'h00100, 5'd0, OP_JAL}, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 5'd0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd0, OP_OP), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{enc_r(7'd1, 5'd2, 5'd1, 3'b000, 5'd4, OP_OP), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd4, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 5'd31, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{enc_i(12'd0, 5'd2, 3'b011, 5'd5, OP_LOAD), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd5, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset held with a valid JAL presented: nothing may be accepted or redirected.
        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b1; ex_ready = 1'b1;
        is_equal = 1'b0; is_lt = 1'b0; is_ltu = 1'b0;
        inst = {20'h00100, 5'd1, OP_JAL}; pc = PC_BASE;
        tick(); tick(); #1;
        check("rst_id_ready", 64'(id_ready), 64'd0);
        check("rst_redirect", 64'(redirect), 64'd0);
        check("rst_pc_sel", 64'(pc_sel), 64'd0);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_pc", ex_pc, 64'd0);
        check("rst_ex_rd", 64'(ex_rd), 64'd0);
        check("rst_ex_ctrl", 64'({ex_imm_sel, ex_has_imm, ex_w_en, ex_is_load, ex_is_store, ex_is_mdiv}), 64'd0);

        tick();
        rst_n = 1'b1;
        inst = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM);
        #1 check("rel_id_ready", 64'(id_ready), 64'd1);
        tick();
        check("rel_ex_valid", 64'(ex_valid), 64'd1);
        check("rel_ex_rd", 64'(ex_rd), 64'd1);
        check("rel_has_imm", 64'(ex_has_imm), 64'd1);
        check("rel_imm_sel", 64'(ex_imm_sel), 64'd0);

        for (int i = 0; i < 16; i++) begin
            inst = vecs[i].inst; pc = PC_BASE + 64'(4 * i);
            is_equal = vecs[i].eq; is_lt = vecs[i].lt; is_ltu = vecs[i].ltu;
            #1;
            check($sformatf("v%0d_id_ready", i), 64'(id_ready), 64'd1);
            check($sformatf("v%0d_redirect", i), 64'(redirect), 64'(vecs[i].redirect));
            check($sformatf("v%0d_pc_sel", i), 64'(pc_sel), 64'(vecs[i].pc_sel));
            tick();
            check($sformatf("v%0d_ex_valid", i), 64'(ex_valid), 64'd1);
            check($sformatf("v%0d_ex_pc", i), ex_pc, PC_BASE + 64'(4 * i));
            check($sformatf("v%0d_ex_rd", i), 64'(ex_rd), 64'(vecs[i].rd));
            check($sformatf("v%0d_ex_rs1", i), 64'(ex_rs1), 64'(vecs[i].inst[19:15]));
            check($sformatf("v%0d_ex_rs2", i), 64'(ex_rs2), 64'(vecs[i].inst[24:20]));
            check($sformatf("v%0d_ctrl", i), 64'({ex_w_en, ex_is_load, ex_is_store, ex_is_mdiv}),
                  64'({vecs[i].w_en, vecs[i].load, vecs[i].store, vecs[i].mdiv}));
            if (vecs[i].chk_imm) begin
                check($sformatf("v%0d_imm_sel", i), 64'(ex_imm_sel), 64'(vecs[i].imm_sel));
                check($sformatf("v%0d_has_imm", i), 64'(ex_has_imm), 64'(vecs[i].has_imm));
            end
        end
        is_equal = 1'b0; is_lt = 1'b0; is_ltu = 1'b0;

        // Load-use on rs1: LD x5 (last table entry) then ADD x6,x5,x7.
        inst = enc_r(7'd0, 5'd7, 5'd5, 3'b000, 5'd6, OP_OP);
        #1 check("lu_stall_ready", 64'(id_ready), 64'd0);
        tick();
        check("lu_bubble", 64'(ex_valid), 64'd0);
        check("lu_bubble_w_en", 64'(ex_w_en), 64'd0);
        #1 check("lu_resume_ready", 64'(id_ready), 64'd1);
        tick();
        check("lu_issue_valid", 64'(ex_valid), 64'd1);
        check("lu_issue_rd", 64'(ex_rd), 64'd6);

        // LD x0 never causes a stall, even for an x0 reader.
        inst = enc_i(12'd0, 5'd2, 3'b011, 5'd0, OP_LOAD);
        tick();
        check("ldx0_w_en", 64'(ex_w_en), 64'd0);
        inst = enc_r(7'd0, 5'd7, 5'd0, 3'b000, 5'd6, OP_OP);
        #1 check("ldx0_ready", 64'(id_ready), 64'd1);
        tick();
        check("ldx0_valid", 64'(ex_valid), 64'd1);

        // rs2 hazard on a taken BEQ: no redirect until the branch is accepted.
        inst = enc_i(12'd0, 5'd2, 3'b011, 5'd9, OP_LOAD);
        tick();
        inst = enc_b(3'b000, 5'd0, 5'd9); is_equal = 1'b1;
        #1;
        check("br_hz_ready", 64'(id_ready), 64'd0);
        check("br_hz_redirect", 64'(redirect), 64'd0);
        check("br_hz_pc_sel", 64'(pc_sel), 64'd0);
        tick();
        check("br_hz_bubble", 64'(ex_valid), 64'd0);
        #1;
        check("br_go_redirect", 64'(redirect), 64'd1);
        check("br_go_pc_sel", 64'(pc_sel), 64'd1);
        tick();
        check("br_go_valid", 64'(ex_valid), 64'd1);
        is_equal = 1'b0;

        // DIV then ADD: ex_valid 1,0,0,0,0,1.
        inst = enc_r(7'd1, 5'd2, 5'd1, 3'b100, 5'd8, OP_OP);
        tick();
        check("div_valid", 64'(ex_valid), 64'd1);
        check("div_mdiv", 64'(ex_is_mdiv), 64'd1);
        inst = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd10, OP_OP);
        for (int k = 0; k < 5; k++) begin
            #1 check($sformatf("div_ready_%0d", k), 64'(id_ready), 64'(k == 4));
            tick();
            check($sformatf("div_valid_%0d", k), 64'(ex_valid), 64'(k == 4));
        end
        check("div_after_rd", 64'(ex_rd), 64'd10);
        check("div_after_mdiv", 64'(ex_is_mdiv), 64'd0);

        // REMUW then flush on the second bubble: back to RUN straight away.
        inst = enc_r(7'd1, 5'd2, 5'd1, 3'b111, 5'd8, OP_OP_32);
        tick();
        check("remuw_mdiv", 64'(ex_is_mdiv), 64'd1);
        inst = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd10, OP_OP);
        #1 check("dflush_b1_ready", 64'(id_ready), 64'd0);
        tick();
        flush = 1'b1;
        #1 check("dflush_b2_ready", 64'(id_ready), 64'd0);
        tick();
        flush = 1'b0;
        check("dflush_valid", 64'(ex_valid), 64'd0);
        #1 check("dflush_run_ready", 64'(id_ready), 64'd1);
        tick();
        check("dflush_add_valid", 64'(ex_valid), 64'd1);
        check("dflush_add_rd", 64'(ex_rd), 64'd10);

        // Async reset in the middle of a divide stall.
        inst = enc_r(7'd1, 5'd2, 5'd1, 3'b100, 5'd8, OP_OP);
        tick();
        inst = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd10, OP_OP);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(ex_valid), 64'd0);
        check("arst_mdiv", 64'(ex_is_mdiv), 64'd0);
        check("arst_rd", 64'(ex_rd), 64'd0);
        check("arst_pc", ex_pc, 64'd0);
        check("arst_ready", 64'(id_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        inst = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM);
        #1 check("arst_rel_ready", 64'(id_ready), 64'd1);
        tick();
        check("arst_rel_valid", 64'(ex_valid), 64'd1);
        check("arst_rel_rd", 64'(ex_rd), 64'd1);

        // Backpressure: three held cycles, then the waiting instruction issues.
        inst = enc_i(12'd1, 5'd0, 3'b000, 5'd11, OP_IMM); pc = PC_BASE + 64'h100;
        tick();
        ex_ready = 1'b0;
        inst = enc_i(12'd2, 5'd0, 3'b000, 5'd12, OP_IMM); pc = PC_BASE + 64'h104;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("bp_ready_%0d", k), 64'(id_ready), 64'd0);
            tick();
            check($sformatf("bp_valid_%0d", k), 64'(ex_valid), 64'd1);
            check($sformatf("bp_rd_%0d", k), 64'(ex_rd), 64'd11);
            check($sformatf("bp_pc_%0d", k), ex_pc, PC_BASE + 64'h100);
        end
        ex_ready = 1'b1;
        #1 check("bp_rel_ready", 64'(id_ready), 64'd1);
        tick();
        check("bp_rel_rd", 64'(ex_rd), 64'd12);
        check("bp_rel_pc", ex_pc, PC_BASE + 64'h104);

        // Flush during a load-use stall on a taken branch.
        inst = enc_i(12'd0, 5'd2, 3'b011, 5'd5, OP_LOAD);
        tick();
        inst = enc_b(3'b000, 5'd5, 5'd0); is_equal = 1'b1; flush = 1'b1;
        #1;
        check("fh_ready", 64'(id_ready), 64'd0);
        check("fh_redirect", 64'(redirect), 64'd0);
        tick();
        flush = 1'b0;
        check("fh_valid", 64'(ex_valid), 64'd0);
        #1;
        check("fh_next_ready", 64'(id_ready), 64'd1);
        check("fh_next_redirect", 64'(redirect), 64'd1);
        tick();
        check("fh_next_valid", 64'(ex_valid), 64'd1);
        is_equal = 1'b0;

        // Flush overrides a backpressure hold.
        ex_ready = 1'b0; flush = 1'b1;
        tick();
        check("fhold_valid", 64'(ex_valid), 64'd0);
        flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
